// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a SIZE x SIZE weight-stationary systolic array.
// One tile job runs weight preload, skewed activation streaming, pipeline
// drain and a single-cycle done pulse.
//
// Handshakes: a beat transfers on a cycle where valid & ready are both high
// at the rising clock edge; ready never depends on valid, and valid may be
// raised or dropped freely by the source between transfers.
module systolic_ctrl #(
    parameter int SIZE   = 16,
    parameter int PE_LAT = 1,
    parameter int KW     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       cfg_k,
    output logic                busy,
    output logic                done,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [8*SIZE-1:0]   w_data,
    output logic                pre_en,
    output logic [8*SIZE-1:0]   pre_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [8*SIZE-1:0]   a_data,
    output logic [8*SIZE-1:0]   row_in,
    output logic                res_valid
);

    // Latency from an activation fire to its result on the bottom-row psums.
    localparam int D   = 2*SIZE - 1 + PE_LAT*(SIZE - 1);
    localparam int WCW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int DCW = $clog2(D + 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(SIZE - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(D - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WCW-1:0]   w_cnt_q, w_cnt_d;
    logic [KW-1:0]    a_cnt_q, a_cnt_d;
    logic [DCW-1:0]   d_cnt_q, d_cnt_d;
    logic [D-1:0]     vld_q, vld_d;

    logic             a_fire;
    logic [8*SIZE-1:0] a_in;

    // Next-state, counters and handshake outputs of the job sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        w_cnt_d = w_cnt_q;
        a_cnt_d = a_cnt_q;
        d_cnt_d = '0;
        busy    = 1'b1;
        done    = 1'b0;
        w_ready = 1'b0;
        a_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy    = 1'b0;
                w_cnt_d = '0;
                a_cnt_d = '0;
                if (start) begin
                    k_d     = cfg_k;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (w_cnt_q == W_LAST) begin
                        w_cnt_d = '0;
                        state_d = (k_q == '0) ? S_DRAIN : S_STREAM;
                    end else begin
                        w_cnt_d = w_cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                // k_q is at least 1 here, so k_q - 1 cannot wrap.
                a_ready = 1'b1;
                if (a_valid) begin
                    a_cnt_d = a_cnt_q + 1'b1;
                    if (a_cnt_q == k_q - 1'b1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Entry cycle is count 0; leave after D cycles so the last
                // result strobe lands in the final DRAIN cycle.
                if (d_cnt_q == D_LAST) begin
                    state_d = S_DONE;
                end else begin
                    d_cnt_d = d_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Preload path: weight row passes straight to the array on each fire.
    always_comb begin
        pre_en   = (state_q == S_LOAD_W) && w_valid;
        pre_data = pre_en ? w_data : '0;
    end

    // Vector entering the skew line: accepted activations, zeros otherwise.
    always_comb begin
        a_fire = (state_q == S_STREAM) && a_valid;
        a_in   = a_fire ? a_data : '0;
        vld_d  = {vld_q[D-2:0], a_fire};
    end

    assign res_valid  = vld_q[D-1];
    assign row_in[7:0] = a_in[7:0];

    // Triangular skew: row r sees the entered vector r cycles late.
    for (genvar r = 1; r < SIZE; r++) begin : g_skew
        logic [7:0] skew_q [r];
        logic [7:0] skew_d [r];

        // Shift this row's delay chain by one stage.
        always_comb begin
            skew_d[0] = a_in[8*r +: 8];
            for (int j = 1; j < r; j++) begin
                skew_d[j] = skew_q[j-1];
            end
        end

        // Delay chain registers, cleared on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < r; j++) begin
                    skew_q[j] <= '0;
                end
            end else begin
                skew_q <= skew_d;
            end
        end

        assign row_in[8*r +: 8] = skew_q[r-1];
    end

    // State, counters and valid delay line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            w_cnt_q <= '0;
            a_cnt_q <= '0;
            d_cnt_q <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_cnt_q <= w_cnt_d;
            a_cnt_q <= a_cnt_d;
            d_cnt_q <= d_cnt_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with SIZE=4, PE_LAT=1 (result latency 10).
// Cycle 0 of each job is the cycle start is presented; cycles count posedges.
module tb_systolic_ctrl;

    localparam int SIZE   = 4;
    localparam int PE_LAT = 1;
    localparam int KW     = 8;
    localparam int W      = 8*SIZE;

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          busy;
    logic          done;
    logic          w_valid;
    logic          w_ready;
    logic [W-1:0]  w_data;
    logic          pre_en;
    logic [W-1:0]  pre_data;
    logic          a_valid;
    logic          a_ready;
    logic [W-1:0]  a_data;
    logic [W-1:0]  row_in;
    logic          res_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle record of what the bench offered and which cycles it expects
    // the activation to be accepted; used to predict the skewed row_in.
    logic [W-1:0] a_hist [0:63];
    logic         fire_hist [0:63];

    systolic_ctrl #(
        .SIZE   (SIZE),
        .PE_LAT (PE_LAT),
        .KW     (KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_k     (cfg_k),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .pre_en    (pre_en),
        .pre_data  (pre_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .row_in    (row_in),
        .res_valid (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 64; i++) begin
            a_hist[i]    = '0;
            fire_hist[i] = 1'b0;
        end
    endtask

    // Row r at cycle c carries row r of the vector accepted at cycle c-r.
    function automatic logic [W-1:0] exp_row_at(input int c);
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < SIZE; r++) begin
            if (c >= r && fire_hist[c-r]) begin
                v[8*r +: 8] = a_hist[c-r][8*r +: 8];
            end
        end
        return v;
    endfunction

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1; start = 1'b1; cfg_k = 8'd5;
        w_valid = 1'b1; a_valid = 1'b1;
        w_data = 32'hdeadbeef; a_data = 32'h12345678;
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                rst = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            obs = {busy, done, w_ready, a_ready, pre_en, res_valid};
            n_checks++;
            if (obs !== 6'b0) begin
                n_fail++;
                $display("FAIL reset flags cycle %0d: got %b expected %b", c, obs, 6'b0);
            end
            n_checks++;
            if (row_in !== '0 || pre_data !== '0) begin
                n_fail++;
                $display("FAIL reset data cycle %0d: row_in %h pre_data %h expected 0", c, row_in, pre_data);
            end
            next_cycle();
        end
        w_valid = 1'b0; a_valid = 1'b0;
    endtask

    task automatic test_basic_job(input string tag);
        logic [5:0] obs, exp_f;
        logic [W-1:0] exp_pre;
        clear_hist();
        for (int c = 5; c <= 7; c++) fire_hist[c] = 1'b1;
        cfg_k = 8'd3; w_valid = 1'b1; a_valid = 1'b1;
        for (int c = 0; c < 22; c++) begin
            start  = (c == 0);
            w_data = {8'(c+3), 8'(c+2), 8'(c+1), 8'(c)};
            a_data = {8'(c+8'h70), 8'(c+8'h60), 8'(c+8'h50), 8'(c+8'h40)};
            a_hist[c] = a_data;
            @(negedge clk);
            obs   = {busy, done, w_ready, a_ready, pre_en, res_valid};
            exp_f = {(c >= 1 && c <= 18), (c == 18), (c >= 1 && c <= 4),
                     (c >= 5 && c <= 7), (c >= 1 && c <= 4), (c >= 15 && c <= 17)};
            exp_pre = (c >= 1 && c <= 4) ? w_data : '0;
            n_checks++;
            if (obs !== exp_f) begin
                n_fail++;
                $display("FAIL %s flags cycle %0d: got %b expected %b", tag, c, obs, exp_f);
            end
            n_checks++;
            if (pre_data !== exp_pre) begin
                n_fail++;
                $display("FAIL %s pre_data cycle %0d: got %h expected %h", tag, c, pre_data, exp_pre);
            end
            n_checks++;
            if (row_in !== exp_row_at(c)) begin
                n_fail++;
                $display("FAIL %s row_in cycle %0d: got %h expected %h", tag, c, row_in, exp_row_at(c));
            end
            next_cycle();
        end
        w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_bubble();
        logic [5:0] obs, exp_f;
        int pulses;
        pulses = 0;
        clear_hist();
        fire_hist[5] = 1'b1; fire_hist[6] = 1'b1; fire_hist[9] = 1'b1;
        cfg_k = 8'd3; w_valid = 1'b1;
        for (int c = 0; c < 23; c++) begin
            start   = (c == 0);
            a_valid = !(c == 7 || c == 8);
            w_data  = {8'(c+8'hb0), 8'(c+8'ha0), 8'(c+8'h90), 8'(c+8'h80)};
            a_data  = {8'(c+8'h31), 8'(c+8'h21), 8'(c+8'h11), 8'(c+8'h01)};
            a_hist[c] = a_data;
            @(negedge clk);
            obs   = {busy, done, w_ready, a_ready, pre_en, res_valid};
            exp_f = {(c >= 1 && c <= 20), (c == 20), (c >= 1 && c <= 4),
                     (c >= 5 && c <= 9), (c >= 1 && c <= 4),
                     (c == 15 || c == 16 || c == 19)};
            if (res_valid === 1'b1) pulses++;
            n_checks++;
            if (obs !== exp_f) begin
                n_fail++;
                $display("FAIL bubble flags cycle %0d: got %b expected %b", c, obs, exp_f);
            end
            n_checks++;
            if (row_in !== exp_row_at(c)) begin
                n_fail++;
                $display("FAIL bubble row_in cycle %0d: got %h expected %h", c, row_in, exp_row_at(c));
            end
            next_cycle();
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL bubble pulse_count: got %0d expected 3", pulses);
        end
        w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_skew();
        logic [5:0] obs, exp_f;
        logic [7:0] exp_b;
        clear_hist();
        fire_hist[5] = 1'b1;
        cfg_k = 8'd1; w_valid = 1'b1; a_valid = 1'b1;
        w_data = 32'h0;
        a_data = 32'h04030201;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            a_hist[c] = a_data;
            @(negedge clk);
            obs   = {busy, done, w_ready, a_ready, pre_en, res_valid};
            exp_f = {(c >= 1 && c <= 16), (c == 16), (c >= 1 && c <= 4),
                     (c == 5), (c >= 1 && c <= 4), (c == 15)};
            n_checks++;
            if (obs !== exp_f) begin
                n_fail++;
                $display("FAIL skew flags cycle %0d: got %b expected %b", c, obs, exp_f);
            end
            n_checks++;
            if (row_in !== exp_row_at(c)) begin
                n_fail++;
                $display("FAIL skew row_in cycle %0d: got %h expected %h", c, row_in, exp_row_at(c));
            end
            if (c >= 5 && c <= 8) begin
                exp_b = 8'(c - 4);
                n_checks++;
                if (row_in[8*(c-5) +: 8] !== exp_b) begin
                    n_fail++;
                    $display("FAIL skew row%0d cycle %0d: got %h expected %h",
                             c-5, c, row_in[8*(c-5) +: 8], exp_b);
                end
            end
            next_cycle();
        end
        w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_k_zero();
        logic [5:0] obs, exp_f;
        cfg_k = 8'd0; w_valid = 1'b1; a_valid = 1'b1;
        a_data = 32'hffffffff;
        for (int c = 0; c < 18; c++) begin
            start  = (c == 0);
            w_data = {8'(c+8'he3), 8'(c+8'hd2), 8'(c+8'hc1), 8'(c+8'hb0)};
            @(negedge clk);
            obs   = {busy, done, w_ready, a_ready, pre_en, res_valid};
            exp_f = {(c >= 1 && c <= 15), (c == 15), (c >= 1 && c <= 4),
                     1'b0, (c >= 1 && c <= 4), 1'b0};
            n_checks++;
            if (obs !== exp_f) begin
                n_fail++;
                $display("FAIL k_zero flags cycle %0d: got %b expected %b", c, obs, exp_f);
            end
            n_checks++;
            if (row_in !== '0) begin
                n_fail++;
                $display("FAIL k_zero row_in cycle %0d: got %h expected 0", c, row_in);
            end
            next_cycle();
        end
        w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        logic [5:0] obs, exp_f;
        logic [W-1:0] exp_row;
        clear_hist();
        fire_hist[5] = 1'b1;
        cfg_k = 8'd3; w_valid = 1'b1;
        for (int c = 0; c < 26; c++) begin
            start   = (c == 0);
            rst     = (c == 6);
            a_valid = (c != 6);
            w_data  = {8'(c+8'h13), 8'(c+8'h12), 8'(c+8'h11), 8'(c+8'h10)};
            a_data  = {8'(c+8'hc0), 8'(c+8'hb0), 8'(c+8'ha0), 8'(c+8'h90)};
            a_hist[c] = a_data;
            @(negedge clk);
            obs   = {busy, done, w_ready, a_ready, pre_en, res_valid};
            exp_f = {(c >= 1 && c <= 6), 1'b0, (c >= 1 && c <= 4),
                     (c >= 5 && c <= 6), (c >= 1 && c <= 4), 1'b0};
            exp_row = (c >= 7) ? '0 : exp_row_at(c);
            n_checks++;
            if (obs !== exp_f) begin
                n_fail++;
                $display("FAIL mid_reset flags cycle %0d: got %b expected %b", c, obs, exp_f);
            end
            n_checks++;
            if (row_in !== exp_row) begin
                n_fail++;
                $display("FAIL mid_reset row_in cycle %0d: got %h expected %h", c, row_in, exp_row);
            end
            next_cycle();
        end
        rst = 1'b0; w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
        test_basic_job("after_reset");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        test_reset();
        test_basic_job("basic");
        test_bubble();
        test_skew();
        test_k_zero();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
